// File: rtl/pc_sequencer_if.sv
// Bundle between the fetch/execute sequencer and its neighbours
// (debug console controls, instruction ROM, CPU datapath, PC).
//
// Signals:
//   restart, run, step     console controls into the sequencer
//   rom_req/rom_ack/data   wait-stated ROM fetch handshake
//   instr/instr_vld        latched instruction towards the CPU
//   exec_done/jump/addr    CPU completion and branch decision
//   pc_rst/load/inc/pc_in  registered PC controls
//   halted/state           debug status
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             restart;
    logic             run;
    logic             step;
    logic             rom_req;
    logic             rom_ack;
    logic [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] instr;
    logic             instr_vld;
    logic             exec_done;
    logic             jump;
    logic [WIDTH-1:0] jump_addr;
    logic             pc_rst;
    logic             pc_load;
    logic             pc_inc;
    logic [WIDTH-1:0] pc_in;
    logic             halted;
    logic [2:0]       state;

    // Sequencer side.
    modport master (
        input  restart, run, step,
        input  rom_ack, rom_data,
        input  exec_done, jump, jump_addr,
        output rom_req, instr, instr_vld,
        output pc_rst, pc_load, pc_inc, pc_in,
        output halted, state
    );

    // Environment side (console, ROM, CPU, PC).
    modport slave (
        output restart, run, step,
        output rom_ack, rom_data,
        output exec_done, jump, jump_addr,
        input  rom_req, instr, instr_vld,
        input  pc_rst, pc_load, pc_inc, pc_in,
        input  halted, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer owning the PC reset/load/inc controls.
// Boots the PC, then loops fetch -> execute -> update under run/step control.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      pc_sequencer_if.master (console, ROM, CPU and PC signals)
//
// Every output is a register so the PC, which samples on the falling
// edge, sees stable controls for a full half cycle.
module pc_sequencer #(
    parameter int WIDTH       = 16,
    parameter int BOOT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    pc_sequencer_if.master     bus
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_IDLE   = 3'd1,
        S_FETCH  = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4
    } state_e;

    localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    boot_cnt_q, boot_cnt_d;
    logic             step_q, step_d;

    logic             pc_rst_q, pc_rst_d;
    logic             halted_q, halted_d;
    logic             rom_req_q, rom_req_d;
    logic             instr_vld_q, instr_vld_d;
    logic             pc_load_q, pc_load_d;
    logic             pc_inc_q, pc_inc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_in_q, pc_in_d;

    logic             take_fetch;
    logic             take_exec;

    // restart wins over any handshake completing in the same cycle
    assign take_fetch = (state_q == S_FETCH) && bus.rom_ack && !bus.restart;
    assign take_exec  = (state_q == S_EXEC) && bus.exec_done && !bus.restart;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= '0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            step_q     <= step_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        step_d     = step_q;
        if (bus.restart) begin
            state_d    = S_BOOT;
            boot_cnt_d = '0;
            step_d     = 1'b0;
        end else begin
            unique case (state_q)
                S_BOOT: begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        boot_cnt_d = '0;
                        state_d    = bus.run ? S_FETCH : S_IDLE;
                    end else begin
                        boot_cnt_d = boot_cnt_q + CW'(1);
                    end
                end
                S_IDLE: begin
                    // run dominates step: no single-step flag when both
                    if (bus.run) begin
                        state_d = S_FETCH;
                    end else if (bus.step) begin
                        state_d = S_FETCH;
                        step_d  = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (take_fetch) state_d = S_EXEC;
                end
                S_EXEC: begin
                    if (take_exec) state_d = S_UPDATE;
                end
                S_UPDATE: begin
                    state_d = (bus.run && !step_q) ? S_FETCH : S_IDLE;
                    step_d  = 1'b0;
                end
                default: begin
                    state_d    = S_BOOT;
                    boot_cnt_d = '0;
                    step_d     = 1'b0;
                end
            endcase
        end
    end

    // ---------------- outputs (next values) ----------------
    always_comb begin
        pc_rst_d    = (state_d == S_BOOT);
        halted_d    = (state_d == S_IDLE);
        rom_req_d   = (state_d == S_FETCH);
        instr_vld_d = (state_d == S_EXEC);
        pc_load_d   = take_exec && bus.jump;
        pc_inc_d    = take_exec && !bus.jump;
        instr_d     = instr_q;
        pc_in_d     = pc_in_q;
        if (take_fetch) instr_d = bus.rom_data;
        if (pc_load_d)  pc_in_d = bus.jump_addr;
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_rst_q    <= 1'b1;
            halted_q    <= 1'b0;
            rom_req_q   <= 1'b0;
            instr_vld_q <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_inc_q    <= 1'b0;
            instr_q     <= '0;
            pc_in_q     <= '0;
        end else begin
            pc_rst_q    <= pc_rst_d;
            halted_q    <= halted_d;
            rom_req_q   <= rom_req_d;
            instr_vld_q <= instr_vld_d;
            pc_load_q   <= pc_load_d;
            pc_inc_q    <= pc_inc_d;
            instr_q     <= instr_d;
            pc_in_q     <= pc_in_d;
        end
    end

    assign bus.pc_rst    = pc_rst_q;
    assign bus.halted    = halted_q;
    assign bus.rom_req   = rom_req_q;
    assign bus.instr_vld = instr_vld_q;
    assign bus.pc_load   = pc_load_q;
    assign bus.pc_inc    = pc_inc_q;
    assign bus.instr     = instr_q;
    assign bus.pc_in     = pc_in_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: PC, ROM and CPU models
// driven on the falling edge, monitor popping expected events.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic reset_n;

    pc_sequencer_if #(.WIDTH(16)) bus ();

    pc_sequencer #(.WIDTH(16), .BOOT_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        jmp;
        logic [15:0] tgt;
    } plan_t;

    typedef struct {
        logic        is_load;
        logic [15:0] tgt;
    } upd_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] pc_model = 16'hDEAD;
    int          rom_wait;
    int          exec_wait;
    plan_t       plan_q[$];
    logic [15:0] exp_fetch[$];
    upd_t        exp_upd[$];
    int          fetch_cnt = 0;
    int          cyc = 0;
    int          fetch_cyc[$];

    function automatic logic [15:0] rom_word(logic [15:0] a);
        return a + 16'd1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // PC, ROM and CPU models, all acting on the falling edge
    initial begin : env
        int    rw_cnt;
        int    ex_cnt;
        logic  have_plan;
        plan_t cur;
        rw_cnt    = 0;
        ex_cnt    = 0;
        have_plan = 1'b0;
        cur.jmp   = 1'b0;
        cur.tgt   = '0;
        forever begin
            @(negedge clk);
            if (bus.pc_rst)       pc_model = 16'h0000;
            else if (bus.pc_load) pc_model = bus.pc_in;
            else if (bus.pc_inc)  pc_model = pc_model + 16'd1;

            if (bus.rom_req && !bus.rom_ack) begin
                if (rw_cnt >= rom_wait) begin
                    bus.rom_ack  = 1'b1;
                    bus.rom_data = rom_word(pc_model);
                end else begin
                    rw_cnt++;
                end
            end else begin
                bus.rom_ack = 1'b0;
                rw_cnt      = 0;
            end

            if (bus.instr_vld && !bus.exec_done) begin
                if (!have_plan) begin
                    if (plan_q.size() > 0) begin
                        cur = plan_q.pop_front();
                    end else begin
                        cur.jmp = 1'b0;
                        cur.tgt = 16'h0;
                    end
                    have_plan = 1'b1;
                end
                if (ex_cnt >= exec_wait) begin
                    bus.exec_done = 1'b1;
                    bus.jump      = cur.jmp;
                    bus.jump_addr = cur.tgt;
                end else begin
                    ex_cnt++;
                end
            end else begin
                bus.exec_done = 1'b0;
                bus.jump      = 1'b0;
                ex_cnt        = 0;
                if (!bus.instr_vld) have_plan = 1'b0;
            end
        end
    end

    // Monitor: fetch completions and PC update pulses
    initial begin : mon
        logic  vld_prev;
        logic [15:0] e;
        upd_t  u;
        vld_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.instr_vld && !vld_prev) begin
                fetch_cnt++;
                fetch_cyc.push_back(cyc);
                if (exp_fetch.size() == 0) begin
                    fail_now("unexpected_fetch");
                end else begin
                    e = exp_fetch.pop_front();
                    check("fetch_pc", 32'(pc_model), 32'(e));
                    check("instr", 32'(bus.instr), 32'(rom_word(pc_model)));
                end
            end
            vld_prev = bus.instr_vld;
            if (bus.pc_load && bus.pc_inc) fail_now("load_and_inc");
            if (bus.pc_load || bus.pc_inc) begin
                if (exp_upd.size() == 0) begin
                    fail_now("unexpected_pc_update");
                end else begin
                    u = exp_upd.pop_front();
                    check("upd_is_load", 32'(bus.pc_load), 32'(u.is_load));
                    if (u.is_load) check("pc_in", 32'(bus.pc_in), 32'(u.tgt));
                end
            end
        end
    end

    task automatic wait_fetches(int n, int budget);
        int i = 0;
        while (fetch_cnt < n && i < budget) begin
            @(posedge clk);
            #2;
            i++;
        end
        if (fetch_cnt < n) fail_now("timeout_fetch");
    endtask

    task automatic wait_halted(int budget);
        int i = 0;
        do begin
            @(posedge clk);
            #2;
            i++;
        end while (!bus.halted && i < budget);
        if (!bus.halted) fail_now("timeout_halt");
    endtask

    function automatic upd_t mk_upd(logic ld, logic [15:0] t);
        upd_t u;
        u.is_load = ld;
        u.tgt     = t;
        return u;
    endfunction

    function automatic plan_t mk_plan(logic j, logic [15:0] t);
        plan_t p;
        p.jmp = j;
        p.tgt = t;
        return p;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        reset_n       = 1'b0;
        bus.run       = 1'b1;
        bus.step      = 1'b0;
        bus.restart   = 1'b0;
        bus.rom_ack   = 1'b0;
        bus.rom_data  = '0;
        bus.exec_done = 1'b0;
        bus.jump      = 1'b0;
        bus.jump_addr = '0;
        rom_wait      = 2;
        exec_wait     = 0;

        // boot and two fall-through instructions
        exp_fetch.push_back(16'h0000);
        exp_fetch.push_back(16'h0001);
        exp_upd.push_back(mk_upd(1'b0, 16'h0));
        exp_upd.push_back(mk_upd(1'b0, 16'h0));

        repeat (3) @(posedge clk);
        #2;
        check("rst_pc_rst", 32'(bus.pc_rst), 32'd1);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_outs", 32'({bus.rom_req, bus.instr_vld, bus.pc_load,
                               bus.pc_inc, bus.halted}), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_pc_in", 32'(bus.pc_in), 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #2;
        end while (bus.pc_rst && n < 20);
        check("boot_edges", 32'(n), 32'd4);
        check("boot_rom_req", 32'(bus.rom_req), 32'd1);
        check("boot_state", 32'(bus.state), 32'd2);
        check("boot_pc", 32'(pc_model), 32'd0);

        wait_fetches(2, 60);
        bus.run = 1'b0;
        wait_halted(60);
        if (fetch_cyc.size() >= 2)
            check("cycles_per_instr", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd5);
        else
            fail_now("cycles_per_instr");
        check("pc_after_two", 32'(pc_model), 32'h0002);
        check("idle_state", 32'(bus.state), 32'd1);

        // taken jump
        plan_q.push_back(mk_plan(1'b1, 16'h1234));
        exp_fetch.push_back(16'h0002);
        exp_fetch.push_back(16'h1234);
        exp_upd.push_back(mk_upd(1'b1, 16'h1234));
        exp_upd.push_back(mk_upd(1'b0, 16'h0));
        bus.run = 1'b1;
        wait_fetches(4, 80);
        bus.run = 1'b0;
        wait_halted(60);
        check("pc_after_jump", 32'(pc_model), 32'h1235);

        // single step, second step during EXEC ignored
        rom_wait  = 0;
        exec_wait = 2;
        exp_fetch.push_back(16'h1235);
        exp_upd.push_back(mk_upd(1'b0, 16'h0));
        @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        wait_fetches(5, 40);
        @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        wait_halted(40);
        check("pc_after_step", 32'(pc_model), 32'h1236);
        repeat (8) @(posedge clk);
        #2;
        check("step_fetches", 32'(fetch_cnt), 32'd5);
        check("step_halted", 32'(bus.halted), 32'd1);

        // restart coincident with exec_done
        rom_wait  = 1;
        exec_wait = 1;
        exp_fetch.push_back(16'h1236);
        exp_fetch.push_back(16'h0000);
        exp_upd.push_back(mk_upd(1'b0, 16'h0));
        bus.run = 1'b1;
        wait_fetches(6, 40);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.exec_done && n < 20);
        if (!bus.exec_done) fail_now("timeout_exec_done");
        bus.restart = 1'b1;
        @(posedge clk);
        #2;
        check("rs_state", 32'(bus.state), 32'd0);
        check("rs_pc_ctl", 32'({bus.pc_load, bus.pc_inc}), 32'd0);
        check("rs_vld", 32'(bus.instr_vld), 32'd0);
        check("rs_pc_rst", 32'(bus.pc_rst), 32'd1);
        @(negedge clk);
        bus.restart = 1'b0;
        wait_fetches(7, 80);
        bus.run = 1'b0;
        wait_halted(60);
        check("pc_after_restart", 32'(pc_model), 32'h0001);

        // PC wrap at 0xFFFF
        rom_wait  = 0;
        exec_wait = 0;
        plan_q.push_back(mk_plan(1'b1, 16'hFFFF));
        exp_fetch.push_back(16'h0001);
        exp_fetch.push_back(16'hFFFF);
        exp_fetch.push_back(16'h0000);
        exp_upd.push_back(mk_upd(1'b1, 16'hFFFF));
        exp_upd.push_back(mk_upd(1'b0, 16'h0));
        exp_upd.push_back(mk_upd(1'b0, 16'h0));
        bus.run = 1'b1;
        wait_fetches(10, 80);
        bus.run = 1'b0;
        wait_halted(60);
        check("pc_after_wrap", 32'(pc_model), 32'h0001);

        repeat (4) @(posedge clk);
        #2;
        check("fetch_left", 32'(exp_fetch.size()), 32'd0);
        check("upd_left", 32'(exp_upd.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
